// File: rtl/car_alarm_chime_driver_if.sv
// Chime driver bus: alarm/acknowledge inputs toward the driver, buzzer and status back.
//   CarAlarmSignal  alarm condition from the decoder (lights on, door open, ignition off)
//   DriverAck       level mute request from the driver
//   Buzzer          buzzer drive, 1 = sounding
//   ChimeActive     chime episode in progress
//   Muted           episode muted (acknowledged or beep budget spent)
//   BeepCount       beeps started in the current episode
interface car_alarm_chime_driver_if #(
  parameter int unsigned CNT_W = 4
);
  logic             CarAlarmSignal;
  logic             DriverAck;
  logic             Buzzer;
  logic             ChimeActive;
  logic             Muted;
  logic [CNT_W-1:0] BeepCount;

  // Tester / alarm decoder side.
  modport master (
    output CarAlarmSignal,
    output DriverAck,
    input  Buzzer,
    input  ChimeActive,
    input  Muted,
    input  BeepCount
  );

  // Chime driver side.
  modport slave (
    input  CarAlarmSignal,
    input  DriverAck,
    output Buzzer,
    output ChimeActive,
    output Muted,
    output BeepCount
  );
endinterface

// File: rtl/car_alarm_chime_driver.sv
// Cabin chime driver: debounces the alarm condition, then sounds a bounded on/off
// beep train that the driver can mute.
//   clk    clock, rising edge
//   reset  synchronous active-high reset
//   bus    car_alarm_chime_driver_if.slave (alarm/ack in; Buzzer, ChimeActive,
//          Muted, BeepCount out -- all registered)
module car_alarm_chime_driver #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned ON_CYC       = 8,
  parameter int unsigned OFF_CYC      = 8,
  parameter int unsigned MAX_BEEPS    = 3,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  car_alarm_chime_driver_if.slave bus
);

  localparam int unsigned ON_OFF_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int unsigned MAX_CYC    = (DEBOUNCE_CYC > ON_OFF_MAX) ? DEBOUNCE_CYC : ON_OFF_MAX;
  localparam int unsigned TIMER_W    = $clog2(MAX_CYC + 1);

  // The entry edge into QUALIFY already counts as one high sample, so the
  // timer only needs to reach DEBOUNCE_CYC-2 while qualifying.
  localparam logic [TIMER_W-1:0] QUAL_LAST = TIMER_W'((DEBOUNCE_CYC >= 2) ? (DEBOUNCE_CYC - 2) : 0);
  localparam logic [TIMER_W-1:0] ON_LAST   = TIMER_W'(ON_CYC - 1);
  localparam logic [TIMER_W-1:0] OFF_LAST  = TIMER_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0]   BEEP_MAX  = CNT_W'(MAX_BEEPS);

  typedef enum logic [2:0] {
    IDLE,
    QUALIFY,
    BEEP_ON,
    BEEP_OFF,
    MUTED
  } chimeState_t;

  chimeState_t        stateQ, stateNext;
  logic [TIMER_W-1:0] timerQ, timerNext;
  logic [CNT_W-1:0]   beepCountQ, beepCountNext;
  logic               buzzerQ, chimeActiveQ, mutedQ;

  logic alarm, ack;
  assign alarm = bus.CarAlarmSignal;
  assign ack   = bus.DriverAck;

  // State, counters and output registers; outputs track the next state so
  // they line up with the state register without an input->output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ       <= IDLE;
      timerQ       <= '0;
      beepCountQ   <= '0;
      buzzerQ      <= 1'b0;
      chimeActiveQ <= 1'b0;
      mutedQ       <= 1'b0;
    end else begin
      stateQ       <= stateNext;
      timerQ       <= timerNext;
      beepCountQ   <= beepCountNext;
      buzzerQ      <= (stateNext == BEEP_ON);
      chimeActiveQ <= (stateNext != IDLE);
      mutedQ       <= (stateNext == MUTED);
    end
  end

  // Next-state: alarm low beats acknowledge, which beats timer expiry.
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      IDLE: begin
        if (alarm) stateNext = (DEBOUNCE_CYC == 1) ? BEEP_ON : QUALIFY;
      end
      QUALIFY: begin
        if (!alarm)                  stateNext = IDLE;
        else if (ack)                stateNext = MUTED;
        else if (timerQ == QUAL_LAST) stateNext = BEEP_ON;
      end
      BEEP_ON: begin
        if (!alarm)                stateNext = IDLE;
        else if (ack)              stateNext = MUTED;
        else if (timerQ == ON_LAST) stateNext = (beepCountQ == BEEP_MAX) ? MUTED : BEEP_OFF;
      end
      BEEP_OFF: begin
        if (!alarm)                 stateNext = IDLE;
        else if (ack)               stateNext = MUTED;
        else if (timerQ == OFF_LAST) stateNext = BEEP_ON;
      end
      MUTED: begin
        if (!alarm) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Timer restarts on every state change and saturates instead of wrapping.
  always_comb begin
    timerNext = timerQ;
    if (stateNext != stateQ)  timerNext = '0;
    else if (timerQ != '1)    timerNext = timerQ + TIMER_W'(1);
  end

  // Beep count starts fresh when an episode leaves IDLE and bumps on each beep start.
  always_comb begin
    beepCountNext = beepCountQ;
    if (stateQ == IDLE && stateNext != IDLE) beepCountNext = '0;
    if (stateNext == BEEP_ON && stateQ != BEEP_ON) beepCountNext = beepCountNext + CNT_W'(1);
  end

  assign bus.Buzzer      = buzzerQ;
  assign bus.ChimeActive = chimeActiveQ;
  assign bus.Muted       = mutedQ;
  assign bus.BeepCount   = beepCountQ;

endmodule

// File: tb/tb_car_alarm_chime_driver.sv
// Bench for car_alarm_chime_driver: directed episodes followed by randomized alarm /
// acknowledge / reset traffic, checked cycle-by-cycle against a beep-train model.
module tb_car_alarm_chime_driver;

  localparam int DEB    = 4;
  localparam int ON     = 8;
  localparam int OFF    = 8;
  localparam int MAXB   = 3;
  localparam int PERIOD = ON + OFF;
  localparam int LASTPOS = MAXB * PERIOD - OFF;

  typedef struct packed {
    logic       bz;
    logic       act;
    logic       mut;
    logic [3:0] cnt;
  } expT;

  logic clk = 1'b0;
  logic reset;
  car_alarm_chime_driver_if #(.CNT_W(4)) bus();

  car_alarm_chime_driver #(
    .DEBOUNCE_CYC(DEB), .ON_CYC(ON), .OFF_CYC(OFF), .MAX_BEEPS(MAXB), .CNT_W(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  expT expQ[$];

  // Reference model: mode 0 quiet, 1 counting high samples, 2 beep train, 3 muted.
  // In the train, pos is cycles since the first beep started; the on/off
  // pattern and beep number fall out of pos by division.
  int mMode = 0, mHighs = 0, mPos = 0, mCnt = 0;

  function automatic void modelEdge(input bit r, input bit a, input bit k);
    if (r) begin
      mMode = 0; mHighs = 0; mPos = 0; mCnt = 0;
    end else if (!a) begin
      mMode = 0; mHighs = 0;
    end else if (k && (mMode == 1 || mMode == 2)) begin
      mMode = 3;
    end else if (mMode == 0 || mMode == 1) begin
      if (mMode == 0) begin mHighs = 0; mCnt = 0; end
      mHighs++;
      if (mHighs >= DEB) begin mMode = 2; mPos = 0; end
      else mMode = 1;
    end else if (mMode == 2) begin
      mPos++;
      if (mPos >= LASTPOS) mMode = 3;
    end
    if (mMode == 2) mCnt = mPos / PERIOD + 1;
  endfunction

  function automatic expT modelOut();
    expT e;
    e.bz  = (mMode == 2) && ((mPos % PERIOD) < ON);
    e.act = (mMode != 0);
    e.mut = (mMode == 3);
    e.cnt = 4'(mCnt);
    return e;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // Drive one edge's inputs (called just after a falling edge) and log the expected result.
  task automatic step(input bit r, input bit a, input bit k);
    reset = r;
    bus.CarAlarmSignal = a;
    bus.DriverAck = k;
    modelEdge(r, a, k);
    expQ.push_back(modelOut());
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit a, input bit k);
    for (int i = 0; i < n; i++) step(1'b0, a, k);
  endtask

  // Monitor: settle after each rising edge, then compare against the oldest expectation.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (expQ.size() != 0) begin
      expT e;
      e = expQ.pop_front();
      check("Buzzer",      int'(bus.Buzzer),      int'(e.bz));
      check("ChimeActive", int'(bus.ChimeActive), int'(e.act));
      check("Muted",       int'(bus.Muted),       int'(e.mut));
      check("BeepCount",   int'(bus.BeepCount),   int'(e.cnt));
    end
  end

  initial begin
    int rate;
    int budget;
    reset = 1'b1;
    bus.CarAlarmSignal = 1'b0;
    bus.DriverAck = 1'b0;
    @(negedge clk);

    // Reset state
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    run(2, 1'b0, 1'b0);

    // Glitch shorter than the debounce window
    run(3, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0);
    check("glitch_count",  int'(bus.BeepCount),   0);
    check("glitch_active", int'(bus.ChimeActive), 0);

    // Full beep train to auto-mute
    run(50, 1'b1, 1'b0);
    check("train_muted",  int'(bus.Muted),     1);
    check("train_buzzer", int'(bus.Buzzer),    0);
    check("train_count",  int'(bus.BeepCount), 3);
    run(2, 1'b1, 1'b1);
    run(2, 1'b0, 1'b0);

    // Acknowledge during the second beep
    run(22, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    run(3, 1'b1, 1'b0);
    check("ack_muted", int'(bus.Muted),     1);
    check("ack_count", int'(bus.BeepCount), 2);
    run(2, 1'b0, 1'b0);

    // Alarm drop in the first off gap, then a fresh episode
    run(15, 1'b1, 1'b0);
    run(2, 1'b0, 1'b0);
    check("drop_active", int'(bus.ChimeActive), 0);
    run(6, 1'b1, 1'b0);
    check("redo_count", int'(bus.BeepCount), 1);
    run(2, 1'b0, 1'b0);

    // Reset mid-beep with the alarm held
    run(7, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("rst_buzzer", int'(bus.Buzzer), 0);
    run(6, 1'b1, 1'b0);

    // Alarm low and acknowledge on the same edge
    run(7, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("tie_muted",  int'(bus.Muted),       0);
    check("tie_active", int'(bus.ChimeActive), 0);
    run(2, 1'b0, 1'b0);

    // Randomized traffic in segments with different alarm-drop rates
    for (int seg = 0; seg < 24; seg++) begin
      case ($urandom_range(0, 2))
        0:       rate = 4;
        1:       rate = 25;
        default: rate = 400;
      endcase
      for (int i = 0; i < 120; i++)
        step($urandom_range(0, 299) == 0,
             $urandom_range(0, rate - 1) != 0,
             $urandom_range(0, 59) == 0);
    end
    run(3, 1'b0, 1'b0);

    budget = 10;
    while (expQ.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (expQ.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain pending=%0d exp=0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
